// File: rtl/formant_pkg.sv
// Shared definitions for the spectrum framer and its formant-stage neighbour.
//   FRAMER_I / FRAMER_FFT_SIZE : default frame geometry
//   I_WIDTH                    : buffer address width (bins kept per frame)
//   BIN_WIDTH                  : input bin counter width (counts up to FFT_SIZE)
//   framer_state_e             : framer FSM states
package formant_pkg;

  localparam int FRAMER_I        = 160;
  localparam int FRAMER_FFT_SIZE = 512;

  localparam int I_WIDTH   = $clog2(FRAMER_I);
  localparam int BIN_WIDTH = $clog2(FRAMER_FFT_SIZE + 1);

  typedef enum logic [1:0] {
    CAPTURE,
    HOLD,
    DRAIN
  } framer_state_e;

endpackage

// File: rtl/spectrum_framer_if.sv
// Stream bundle between the FFT, the spectrum framer and the formant stage.
//   fft_in_*      : complex FFT bins, one per valid beat, last on bin FFT_SIZE-1
//   formant_ready : formant stage idle, may accept a burst
//   fft_valid/fft_data : power burst, I consecutive beats
//   frame_dropped : one-cycle pulse per discarded input frame
//   busy          : framer holding or draining a frame
// master = the environment side (FFT + formant stage), slave = the framer.
interface spectrum_framer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int BIT_WIDTH = 32
);

  logic                       fft_in_valid;
  logic signed [IN_WIDTH-1:0] fft_in_re;
  logic signed [IN_WIDTH-1:0] fft_in_im;
  logic                       fft_in_last;
  logic                       formant_ready;
  logic                       fft_valid;
  logic [BIT_WIDTH-1:0]       fft_data;
  logic                       frame_dropped;
  logic                       busy;

  modport master (
    output fft_in_valid, fft_in_re, fft_in_im, fft_in_last, formant_ready,
    input  fft_valid, fft_data, frame_dropped, busy
  );

  modport slave (
    input  fft_in_valid, fft_in_re, fft_in_im, fft_in_last, formant_ready,
    output fft_valid, fft_data, frame_dropped, busy
  );

endinterface

// File: rtl/spectrum_framer_ram.sv
// True dual-port, read-first, single-clock block RAM.
//   Port A/B : addr, din, we, en, rst (output register reset), regce, dout
//   HIGH_PERFORMANCE adds an output register: 2-cycle read latency.
//   LOW_LATENCY returns the array register directly: 1-cycle read latency.
// Both ports write the same array, so writes live in one process; a same-address
// collision resolves in favour of port B.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int RAM_WIDTH       = 18,
  parameter int RAM_DEPTH       = 1024,
  parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic [RAM_WIDTH-1:0]         dinb,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         web,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         rsta,
  input  logic                         rstb,
  input  logic                         regcea,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         douta,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;
  logic [RAM_WIDTH-1:0] ram_data_b;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data_a <= mem[addra];
    end
    if (enb) begin
      if (web) mem[addrb] <= dinb;
      ram_data_b <= mem[addrb];
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
    assign douta = ram_data_a;
    assign doutb = ram_data_b;
  end else begin : g_out_reg
    always_ff @(posedge clka) begin
      if (rsta)        douta <= '0;
      else if (regcea) douta <= ram_data_a;
      if (rstb)        doutb <= '0;
      else if (regceb) doutb <= ram_data_b;
    end
  end

endmodule

// File: rtl/spectrum_framer.sv
// Spectrum framer: turns the complex FFT stream into power bursts for the
// formant stage.
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (slave)    : FFT input stream in, power burst / status out
// Bins 0..I-1 of each well-formed frame are squared (|X|^2, saturating to
// BIT_WIDTH), buffered, and replayed as one uninterrupted I-beat burst once the
// formant stage is idle. Malformed frames and frames that arrive while a frame
// is held or draining are dropped with a one-cycle frame_dropped pulse.
// Overrides of I / FFT_SIZE must fit in the package widths I_WIDTH / BIN_WIDTH.
module spectrum_framer
  import formant_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int I         = FRAMER_I,
  parameter int FFT_SIZE  = FRAMER_FFT_SIZE,
  parameter int IN_WIDTH  = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  spectrum_framer_if.slave bus
);

  localparam int STAGES = 2;
  localparam int PW     = 2 * IN_WIDTH;
  localparam int SUM_W  = 2 * IN_WIDTH + 1;

  // ---------------- input bin counter ----------------
  logic [BIN_WIDTH-1:0] bin_cnt_q, bin_cnt_d;

  always_comb begin
    bin_cnt_d = bin_cnt_q;
    if (bus.fft_in_valid) begin
      if (bus.fft_in_last)                            bin_cnt_d = '0;
      else if (bin_cnt_q != BIN_WIDTH'(FFT_SIZE))     bin_cnt_d = bin_cnt_q + BIN_WIDTH'(1);
    end
  end

  // ---------------- power pipeline ----------------
  // Stage 1 squares, stage 2 sums and saturates; bin tag and last ride along.
  logic [STAGES:1]      vld_pipe_q;
  logic [PW-1:0]        sq_re_q, sq_re_d, sq_im_q, sq_im_d;
  logic [BIN_WIDTH-1:0] p1_bin_q, p2_bin_q;
  logic                 p1_last_q, p2_last_q;
  logic [BIT_WIDTH-1:0] p2_power_q, p2_power_d;
  logic signed [PW-1:0] re_x, im_x;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    re_x    = PW'(bus.fft_in_re);
    im_x    = PW'(bus.fft_in_im);
    sq_re_d = re_x * re_x;
    sq_im_d = im_x * im_x;
  end

  always_comb begin
    sum        = {1'b0, sq_re_q} + {1'b0, sq_im_q};
    // Any bit above BIT_WIDTH set means the power does not fit: clamp.
    p2_power_d = (|(sum >> BIT_WIDTH)) ? '1 : BIT_WIDTH'(sum);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bin_cnt_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      bin_cnt_q  <= bin_cnt_d;
      vld_pipe_q <= {vld_pipe_q[1], bus.fft_in_valid};
    end
    sq_re_q    <= sq_re_d;
    sq_im_q    <= sq_im_d;
    p1_bin_q   <= bin_cnt_q;
    p1_last_q  <= bus.fft_in_last;
    p2_bin_q   <= p1_bin_q;
    p2_last_q  <= p1_last_q;
    p2_power_q <= p2_power_d;
  end

  // ---------------- frame control ----------------
  framer_state_e      state_q;
  logic [I_WIDTH-1:0] rd_cnt_q;
  logic [2:1]         rd_pipe_q;
  logic               synced_q, mid_frame_q, busy_q, dropped_q;

  logic p2_vld, rd_en, drain_done, store, complete, drop, mid_frame_nxt;

  always_comb begin
    p2_vld        = vld_pipe_q[STAGES];
    rd_en         = (state_q == DRAIN);
    drain_done    = rd_en && (rd_cnt_q == I_WIDTH'(I - 1));
    store         = p2_vld && (state_q == CAPTURE) && synced_q &&
                    (p2_bin_q < BIN_WIDTH'(I));
    complete      = p2_vld && p2_last_q && (state_q == CAPTURE) && synced_q &&
                    (p2_bin_q == BIN_WIDTH'(FFT_SIZE - 1));
    drop          = p2_vld && p2_last_q && !complete;
    // Frame-in-progress as seen at the pipeline output, including this beat;
    // tracked here so a frame that just ended on the DRAIN-exit edge is not
    // mistaken for one still running.
    mid_frame_nxt = p2_vld ? !p2_last_q : mid_frame_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= CAPTURE;
      rd_cnt_q    <= '0;
      rd_pipe_q   <= '0;
      synced_q    <= 1'b1;
      mid_frame_q <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      dropped_q   <= drop;
      mid_frame_q <= mid_frame_nxt;
      rd_pipe_q   <= {rd_pipe_q[1], rd_en};
      if (p2_vld && p2_last_q) synced_q <= 1'b1;
      case (state_q)
        CAPTURE: if (complete) begin
          state_q <= HOLD;
          busy_q  <= 1'b1;
        end
        HOLD: if (bus.formant_ready) state_q <= DRAIN;
        DRAIN: begin
          rd_cnt_q <= rd_cnt_q + I_WIDTH'(1);
          if (drain_done) begin
            state_q  <= CAPTURE;
            busy_q   <= 1'b0;
            rd_cnt_q <= '0;
            // A frame already under way is partial: skip it up to its last.
            if (mid_frame_nxt) synced_q <= 1'b0;
          end
        end
        default: state_q <= CAPTURE;
      endcase
    end
  end

  // ---------------- frame buffer ----------------
  logic [BIT_WIDTH-1:0] ram_doutb;
  logic [BIT_WIDTH-1:0] unused_douta;

  // Output register only loads on a returning read, so fft_data holds between
  // bursts and clears on reset.
  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH      (BIT_WIDTH),
    .RAM_DEPTH      (I),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE")
  ) u_buf (
    .addra  (p2_bin_q[I_WIDTH-1:0]),
    .addrb  (rd_cnt_q),
    .dina   (p2_power_q),
    .dinb   ('0),
    .clka   (clk_in),
    .wea    (store),
    .web    (1'b0),
    .ena    (store),
    .enb    (rd_en),
    .rsta   (rst_in),
    .rstb   (rst_in),
    .regcea (1'b1),
    .regceb (rd_pipe_q[1]),
    .douta  (unused_douta),
    .doutb  (ram_doutb)
  );

  assign bus.fft_valid     = rd_pipe_q[2];
  assign bus.fft_data      = ram_doutb;
  assign bus.frame_dropped = dropped_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_spectrum_framer.sv
module tb_spectrum_framer;

  logic clk;
  logic rst;

  spectrum_framer_if #(.IN_WIDTH(16), .BIT_WIDTH(32)) bus   ();
  spectrum_framer_if #(.IN_WIDTH(16), .BIT_WIDTH(31)) bus31 ();

  spectrum_framer #(.BIT_WIDTH(32), .I(160), .FFT_SIZE(512), .IN_WIDTH(16)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );
  spectrum_framer #(.BIT_WIDTH(31), .I(160), .FFT_SIZE(512), .IN_WIDTH(16)) dut31 (
    .clk_in(clk), .rst_in(rst), .bus(bus31)
  );

  assign bus31.fft_in_valid  = bus.fft_in_valid;
  assign bus31.fft_in_re     = bus.fft_in_re;
  assign bus31.fft_in_im     = bus.fft_in_im;
  assign bus31.fft_in_last   = bus.fft_in_last;
  assign bus31.formant_ready = bus.formant_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // burst / drop monitor
  logic [31:0] data_q[$];
  logic [30:0] data31_q[$];
  int          runs_q[$];
  int          run_len  = 0;
  int          drop_cnt = 0;

  always @(negedge clk) begin
    if (bus.fft_valid === 1'b1) begin
      data_q.push_back(bus.fft_data);
      data31_q.push_back(bus31.fft_data);
      run_len++;
    end else if (run_len != 0) begin
      runs_q.push_back(run_len);
      run_len = 0;
    end
    if (bus.frame_dropped === 1'b1) drop_cnt++;
  end

  // pattern 0: re=k, im=0 ; 1: as 0 but bin 3 = (-32768,-32768) ; 2: re=0, im=k+1
  function automatic int stim_re(int pat, int k);
    if (pat == 1 && k == 3) return -32768;
    if (pat == 2) return 0;
    return k;
  endfunction

  function automatic int stim_im(int pat, int k);
    if (pat == 1 && k == 3) return -32768;
    if (pat == 2) return k + 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_pow(int pat, int k, int bw);
    longint r, i, p, lim;
    r   = stim_re(pat, k);
    i   = stim_im(pat, k);
    lim = (longint'(1) << bw) - 1;
    p   = r * r + i * i;
    if (p > lim) p = lim;
    return 32'(p);
  endfunction

  task automatic send_frame(input int nbeats, input int pat);
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      bus.fft_in_valid = 1'b1;
      bus.fft_in_re    = 16'(stim_re(pat, k));
      bus.fft_in_im    = 16'(stim_im(pat, k));
      bus.fft_in_last  = (k == nbeats - 1);
    end
    @(negedge clk);
    bus.fft_in_valid = 1'b0;
    bus.fft_in_last  = 1'b0;
  endtask

  task automatic clear_mon();
    @(posedge clk);
    data_q.delete();
    data31_q.delete();
    runs_q.delete();
    run_len  = 0;
    drop_cnt = 0;
  endtask

  task automatic wait_runs(input int n, input int limit);
    for (int c = 0; c < limit && runs_q.size() < n; c++) @(negedge clk);
  endtask

  task automatic wait_valid(input int limit);
    for (int c = 0; c < limit && bus.fft_valid !== 1'b1; c++) @(negedge clk);
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.fft_valid !== 1'b0) begin errors++; $display("FAIL reset_fft_valid: got %b want 0", bus.fft_valid); end
    checks++; if (bus.fft_data !== 32'd0) begin errors++; $display("FAIL reset_fft_data: got %h want 0", bus.fft_data); end
    checks++; if (bus.frame_dropped !== 1'b0) begin errors++; $display("FAIL reset_frame_dropped: got %b want 0", bus.frame_dropped); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus31.fft_data !== 31'd0) begin errors++; $display("FAIL reset_fft_data31: got %h want 0", bus31.fft_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int lat;
    bus.formant_ready = 1'b1;
    clear_mon();
    send_frame(512, 1);
    lat = 1;
    while (bus.fft_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    checks++; if (lat != 6) begin errors++; $display("FAIL single_latency: got %0d want 6", lat); end
    wait_runs(1, 400);
    checks++; if (runs_q.size() != 1 || runs_q[0] != 160) begin errors++; $display("FAIL single_run: runs %0d first %0d want 1 x 160", runs_q.size(), (runs_q.size() > 0) ? runs_q[0] : -1); end
    checks++; if (data_q.size() != 160) begin errors++; $display("FAIL single_len: got %0d want 160", data_q.size()); end
    for (int k = 0; k < 160 && k < data_q.size(); k++) begin
      checks++; if (data_q[k] !== exp_pow(1, k, 32)) begin errors++; $display("FAIL single_word%0d: got %h want %h", k, data_q[k], exp_pow(1, k, 32)); end
    end
    if (data_q.size() == 160) begin
      checks++; if (data_q[3] !== 32'h8000_0000) begin errors++; $display("FAIL single_bin3: got %h want 80000000", data_q[3]); end
      checks++; if (data_q[159] !== 32'd25281) begin errors++; $display("FAIL single_bin159: got %0d want 25281", data_q[159]); end
    end
    checks++; if (data31_q.size() != 160) begin errors++; $display("FAIL sat31_len: got %0d want 160", data31_q.size()); end
    if (data31_q.size() == 160) begin
      checks++; if (data31_q[3] !== 31'h7FFF_FFFF) begin errors++; $display("FAIL sat31_bin3: got %h want 7fffffff", data31_q[3]); end
      checks++; if (data31_q[5] !== 31'd25) begin errors++; $display("FAIL sat31_bin5: got %0d want 25", data31_q[5]); end
    end
    checks++; if (drop_cnt != 0) begin errors++; $display("FAIL single_drops: got %0d want 0", drop_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (bus.fft_data !== 32'd25281) begin errors++; $display("FAIL single_hold_data: got %0d want 25281", bus.fft_data); end
  endtask

  task automatic test_hold_wait();
    int lat;
    bus.formant_ready = 1'b0;
    clear_mon();
    send_frame(512, 0);
    send_frame(512, 2);
    repeat (500) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b want 1", bus.busy); end
    checks++; if (data_q.size() != 0) begin errors++; $display("FAIL hold_no_burst: got %0d beats want 0", data_q.size()); end
    checks++; if (drop_cnt != 1) begin errors++; $display("FAIL hold_drops: got %0d want 1", drop_cnt); end
    bus.formant_ready = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (bus.fft_valid !== 1'b1 && lat < 50);
    checks++; if (lat != 3) begin errors++; $display("FAIL hold_latency: got %0d want 3", lat); end
    wait_runs(1, 400);
    checks++; if (runs_q.size() != 1 || data_q.size() != 160) begin errors++; $display("FAIL hold_run: runs %0d beats %0d want 1 x 160", runs_q.size(), data_q.size()); end
    for (int k = 0; k < 160 && k < data_q.size(); k++) begin
      checks++; if (data_q[k] !== exp_pow(0, k, 32)) begin errors++; $display("FAIL hold_word%0d: got %h want %h", k, data_q[k], exp_pow(0, k, 32)); end
    end
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_bad_frames();
    bus.formant_ready = 1'b1;
    clear_mon();
    send_frame(301, 0);
    repeat (10) @(negedge clk);
    checks++; if (drop_cnt != 1) begin errors++; $display("FAIL short_drop: got %0d want 1", drop_cnt); end
    send_frame(520, 0);
    repeat (300) @(negedge clk);
    checks++; if (drop_cnt != 2) begin errors++; $display("FAIL long_drop: got %0d want 2", drop_cnt); end
    checks++; if (data_q.size() != 0) begin errors++; $display("FAIL bad_no_burst: got %0d beats want 0", data_q.size()); end
    send_frame(512, 0);
    wait_runs(1, 400);
    checks++; if (runs_q.size() != 1 || data_q.size() != 160) begin errors++; $display("FAIL recover_run: runs %0d beats %0d want 1 x 160", runs_q.size(), data_q.size()); end
    for (int k = 0; k < 160 && k < data_q.size(); k++) begin
      checks++; if (data_q[k] !== exp_pow(0, k, 32)) begin errors++; $display("FAIL recover_word%0d: got %h want %h", k, data_q[k], exp_pow(0, k, 32)); end
    end
    checks++; if (drop_cnt != 2) begin errors++; $display("FAIL recover_drops: got %0d want 2", drop_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    bus.formant_ready = 1'b1;
    clear_mon();
    send_frame(512, 0);
    wait_valid(50);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.fft_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.fft_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    clear_mon();
    send_frame(512, 2);
    wait_runs(1, 400);
    checks++; if (runs_q.size() != 1 || data_q.size() != 160) begin errors++; $display("FAIL rstmid_run: runs %0d beats %0d want 1 x 160", runs_q.size(), data_q.size()); end
    for (int k = 0; k < 160 && k < data_q.size(); k++) begin
      checks++; if (data_q[k] !== exp_pow(2, k, 32)) begin errors++; $display("FAIL rstmid_word%0d: got %h want %h", k, data_q[k], exp_pow(2, k, 32)); end
    end
  endtask

  task automatic test_ready_toggle();
    bus.formant_ready = 1'b1;
    clear_mon();
    send_frame(512, 0);
    wait_valid(50);
    repeat (10) @(negedge clk);
    bus.formant_ready = 1'b0;
    wait_runs(1, 400);
    repeat (20) @(negedge clk);
    checks++; if (runs_q.size() != 1 || runs_q[0] != 160) begin errors++; $display("FAIL toggle_run: runs %0d first %0d want 1 x 160", runs_q.size(), (runs_q.size() > 0) ? runs_q[0] : -1); end
    for (int k = 0; k < 160 && k < data_q.size(); k++) begin
      checks++; if (data_q[k] !== exp_pow(0, k, 32)) begin errors++; $display("FAIL toggle_word%0d: got %h want %h", k, data_q[k], exp_pow(0, k, 32)); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL toggle_busy: got %b want 0", bus.busy); end
    bus.formant_ready = 1'b1;
  endtask

  // Frame 2 starts while frame 1 drains: it is partial when DRAIN ends, so it
  // is dropped on its last; frame 3 is captured normally.
  task automatic test_back_to_back();
    bus.formant_ready = 1'b1;
    clear_mon();
    send_frame(512, 0);
    send_frame(512, 2);
    send_frame(512, 2);
    wait_runs(2, 800);
    checks++; if (runs_q.size() != 2 || data_q.size() != 320) begin errors++; $display("FAIL b2b_runs: runs %0d beats %0d want 2 x 160", runs_q.size(), data_q.size()); end
    checks++; if (drop_cnt != 1) begin errors++; $display("FAIL b2b_drops: got %0d want 1", drop_cnt); end
    for (int k = 0; k < 320 && k < data_q.size(); k++) begin
      checks++;
      if (data_q[k] !== ((k < 160) ? exp_pow(0, k, 32) : exp_pow(2, k - 160, 32))) begin
        errors++; $display("FAIL b2b_word%0d: got %h want %h", k, data_q[k], (k < 160) ? exp_pow(0, k, 32) : exp_pow(2, k - 160, 32));
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.fft_in_valid  = 1'b0;
    bus.fft_in_re     = '0;
    bus.fft_in_im     = '0;
    bus.fft_in_last   = 1'b0;
    bus.formant_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_hold_wait();
    test_bad_frames();
    test_reset_mid_burst();
    test_ready_toggle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
